// File: rtl/pmem_loader.sv
// Program loader: turns a stream of source characters into 3-bit opcodes written
// sequentially into program memory, then releases the core once brackets balance.
module pmem_loader #(
  parameter int ADDR_W  = 16,
  parameter int MAX_LEN = 65536,
  parameter int NEST_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              pmem_we,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [2:0]        pmem_data,
  output logic              core_run,
  output logic [ADDR_W:0]   prog_len,
  output logic              error,
  output logic [1:0]        err_code
);

  localparam logic [1:0]        S_LOAD       = 2'd0;
  localparam logic [1:0]        S_DONE       = 2'd1;
  localparam logic [1:0]        S_ERROR      = 2'd2;
  localparam logic [7:0]        LP_EOT       = 8'h04;
  localparam logic [ADDR_W:0]   LP_MAX_LEN   = (ADDR_W+1)'(MAX_LEN);
  localparam logic [ADDR_W:0]   LP_LEN_ONE   = (ADDR_W+1)'(1);
  localparam logic [NEST_W-1:0] LP_MAX_DEPTH = '1;
  localparam logic [NEST_W-1:0] LP_DEPTH_ONE = NEST_W'(1);
  localparam logic [2:0]        OP_OPEN      = 3'd4;
  localparam logic [2:0]        OP_CLOSE     = 3'd5;

  logic [1:0]        r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_data;
  logic              r_core_run;
  logic [ADDR_W:0]   r_len;
  logic              r_error;
  logic [1:0]        r_err_code;
  logic [NEST_W-1:0] r_depth;

  logic              w_xfer;
  logic              w_is_op;
  logic [2:0]        w_opc;
  logic              w_err;
  logic [1:0]        w_err_code;

  assign w_xfer = in_valid && (r_state == S_LOAD);

  always_comb begin
    w_is_op = 1'b1;
    w_opc   = 3'd0;
    case (in_data)
      8'h2B:   w_opc = 3'd0;
      8'h2D:   w_opc = 3'd1;
      8'h3E:   w_opc = 3'd2;
      8'h3C:   w_opc = 3'd3;
      8'h5B:   w_opc = 3'd4;
      8'h5D:   w_opc = 3'd5;
      8'h2E:   w_opc = 3'd6;
      8'h2C:   w_opc = 3'd7;
      default: w_is_op = 1'b0;
    endcase
  end

  // Error causes are prioritised: memory full beats bracket problems.
  always_comb begin
    w_err      = 1'b0;
    w_err_code = 2'd0;
    if (r_len == LP_MAX_LEN) begin
      w_err      = 1'b1;
      w_err_code = 2'd1;
    end else if ((w_opc == OP_CLOSE) && (r_depth == '0)) begin
      w_err      = 1'b1;
      w_err_code = 2'd2;
    end else if ((w_opc == OP_OPEN) && (r_depth == LP_MAX_DEPTH)) begin
      w_err      = 1'b1;
      w_err_code = 2'd3;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_LOAD;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= 3'd0;
      r_core_run <= 1'b0;
      r_len      <= '0;
      r_error    <= 1'b0;
      r_err_code <= 2'd0;
      r_depth    <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_xfer) begin
        if (in_data == LP_EOT) begin
          if (r_depth == '0) begin
            r_state    <= S_DONE;
            r_core_run <= 1'b1;
          end else begin
            r_state    <= S_ERROR;
            r_error    <= 1'b1;
            r_err_code <= 2'd2;
          end
        end else if (w_is_op) begin
          if (w_err) begin
            r_state    <= S_ERROR;
            r_error    <= 1'b1;
            r_err_code <= w_err_code;
          end else begin
            // r_len < MAX_LEN <= 2**ADDR_W here, so the low bits are the address.
            r_we   <= 1'b1;
            r_addr <= r_len[ADDR_W-1:0];
            r_data <= w_opc;
            r_len  <= r_len + LP_LEN_ONE;
            if (w_opc == OP_OPEN) begin
              r_depth <= r_depth + LP_DEPTH_ONE;
            end else if (w_opc == OP_CLOSE) begin
              r_depth <= r_depth - LP_DEPTH_ONE;
            end
          end
        end
      end
    end
  end

  assign in_ready  = (r_state == S_LOAD);
  assign pmem_we   = r_we;
  assign pmem_addr = r_addr;
  assign pmem_data = r_data;
  assign core_run  = r_core_run;
  assign prog_len  = r_len;
  assign error     = r_error;
  assign err_code  = r_err_code;

endmodule
